logchange_replay: RTL

- Receiver for the change-logger byte stream.
- Accepts bytes over the logger's data_valid/next handshake and reassembles them into (NSIG+1)-bit records.
- Decodes sample, timestamp and overflow-marker records, and replays the captured waveform cycle by cycle on sig_out.
- Sits on the host/replay side of the debug link, either on-chip for loopback checking or in an emulation harness.

---
 rtl/logchange_replay_pkg.sv | 18 +
 rtl/logchange_unpack.sv | 67 ++++++
 rtl/logchange_replay.sv | 106 ++++++++++
 3 files changed

// File: rtl/logchange_replay_pkg.sv
// Shared definitions for the change-logger record format and the replay FSM.
// Record flag bit is bit NSIG; marker and trailer are uniform fills of all NSIG+1 bits.
package logchange_replay_pkg;

    typedef enum logic [1:0] {
        ASSEMBLE = 2'd0,
        OVF      = 2'd1,
        STOPPED  = 2'd2
    } state_t;

    localparam logic MARKER_FILL  = 1'b1;
    localparam logic TRAILER_FILL = 1'b0;

    function automatic int calc_nbytes(input int nsig);
        return (nsig + 1 + 7) / 8;
    endfunction

endpackage

// File: rtl/logchange_unpack.sv
// Byte-to-record assembler: little-endian byte index, one-deep record buffer,
// and the in_next handshake toward the logger.
module logchange_unpack
    import logchange_replay_pkg::*;
#(
    parameter int NSIG = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_valid,
    input  logic [7:0]    i_data,
    input  logic          i_consume,
    input  logic          i_stopped,
    output logic          o_next,
    output logic          o_buf_full,
    output logic [NSIG:0] o_record
);

    localparam int NBYTES   = calc_nbytes(NSIG);
    localparam int IDXW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int LOW_BITS = 8 * (NBYTES - 1);
    localparam int AW       = (NBYTES > 1) ? LOW_BITS : 8;

    logic [IDXW-1:0] r_idx;
    logic [AW-1:0]   r_asm;
    logic [NSIG:0]   r_buf;
    logic            r_buf_full;
    logic [NSIG:0]   w_rec;
    logic            w_xfer;
    logic            w_last;

    assign o_next     = i_valid && !r_buf_full && !i_stopped;
    assign w_xfer     = o_next;
    assign w_last     = (r_idx == IDXW'(NBYTES - 1));
    assign o_buf_full = r_buf_full;
    assign o_record   = r_buf;

    // The final byte is merged straight into the record; its bits above NSIG are dropped.
    if (NBYTES > 1) begin : g_multi
        assign w_rec = {i_data[NSIG-LOW_BITS:0], r_asm};
    end else begin : g_single
        assign w_rec = i_data[NSIG:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx      <= '0;
            r_asm      <= '0;
            r_buf      <= '0;
            r_buf_full <= 1'b0;
        end else begin
            if (w_xfer) begin
                if (w_last) begin
                    r_idx <= '0;
                    r_buf <= w_rec;
                end else begin
                    r_idx <= r_idx + 1'b1;
                    for (int k = 0; k < NBYTES - 1; k++) begin
                        if (r_idx == IDXW'(k)) r_asm[8*k +: 8] <= i_data;
                    end
                end
            end
            r_buf_full <= (r_buf_full && !i_consume) || (w_xfer && w_last);
        end
    end

endmodule

// File: rtl/logchange_replay.sv
// Change-logger receiver: reassembles records and replays samples on sig_out,
// honouring timestamp holds and the overflow marker/trailer termination.
module logchange_replay
    import logchange_replay_pkg::*;
#(
    parameter int NSIG = 12,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic [7:0]      in_data,
    output logic            in_next,
    input  logic            run,
    output logic [NSIG-1:0] sig_out,
    output logic            sig_strobe,
    output logic            overflow,
    output logic            fmt_err,
    output logic            stopped,
    output logic [CNTW-1:0] rec_count,
    output logic [1:0]      o_dbg_state
);

    localparam int NBYTES = calc_nbytes(NSIG);

    state_t          r_state;
    state_t          w_state_next;
    logic [NSIG-1:0] r_sig;
    logic [NSIG-1:0] r_hold;
    logic            r_strobe;
    logic            r_overflow;
    logic            r_fmt_err;
    logic [CNTW-1:0] r_rec_count;
    logic            w_buf_full;
    logic [NSIG:0]   w_rec;
    logic            w_consume;
    logic            w_is_marker;
    logic            w_is_trailer;
    logic            w_is_flag;

    logchange_unpack #(.NSIG(NSIG)) u_unpack (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_valid    (in_valid),
        .i_data     (in_data),
        .i_consume  (w_consume),
        .i_stopped  (r_state == STOPPED),
        .o_next     (in_next),
        .o_buf_full (w_buf_full),
        .o_record   (w_rec)
    );

    assign w_is_marker  = (w_rec == {(NSIG+1){MARKER_FILL}});
    assign w_is_trailer = (w_rec == {(NSIG+1){TRAILER_FILL}});
    assign w_is_flag    = w_rec[NSIG];
    assign w_consume    = w_buf_full && run && (r_hold == '0) && (r_state != STOPPED);

    assign sig_out     = r_sig;
    assign sig_strobe  = r_strobe;
    assign overflow    = r_overflow;
    assign fmt_err     = r_fmt_err;
    assign stopped     = (r_state == STOPPED);
    assign rec_count   = r_rec_count;
    assign o_dbg_state = r_state;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ASSEMBLE: if (w_consume && w_is_marker) w_state_next = OVF;
            OVF:      if (w_consume)                w_state_next = STOPPED;
            default:                                w_state_next = STOPPED;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ASSEMBLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sig       <= '0;
            r_hold      <= '0;
            r_strobe    <= 1'b0;
            r_overflow  <= 1'b0;
            r_fmt_err   <= 1'b0;
            r_rec_count <= '0;
        end else begin
            r_strobe <= w_consume && (r_state == ASSEMBLE) && !w_is_flag;
            if (w_consume && (r_state == ASSEMBLE) && !w_is_flag) r_sig <= w_rec[NSIG-1:0];
            // A freshly consumed timestamp loads the hold; otherwise count down only while running.
            if (w_consume && (r_state == ASSEMBLE) && w_is_flag && !w_is_marker) begin
                r_hold <= w_rec[NSIG-1:0];
            end else if (run && (r_hold != '0)) begin
                r_hold <= r_hold - 1'b1;
            end
            if (w_consume && (r_state == ASSEMBLE) && w_is_marker) r_overflow <= 1'b1;
            if (w_consume && (r_state == OVF) && !w_is_trailer)    r_fmt_err  <= 1'b1;
            if (w_consume && (r_rec_count != '1)) r_rec_count <= r_rec_count + 1'b1;
        end
    end

endmodule
